// File: rtl/atm_pkg.sv
// Shared definitions for the ATM PIN-entry block: state encoding, keypad
// codes and a helper for sizing the BCD digit buffer.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_VERIFY  = 3'd2,
        ST_GRANTED = 3'd3,
        ST_LOCKED  = 3'd4,
        ST_ABORT   = 3'd5
    } state_t;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    // Each PIN digit is one BCD nibble.
    function automatic int buf_width(input int digits);
        return 4 * digits;
    endfunction

endpackage

// File: rtl/atm_timeout_ctr.sv
// Inactivity counter for the PIN-entry session. It counts enabled cycles
// since the last restart and saturates at the terminal count, where expired
// is flagged.
module atm_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: restart wins, otherwise count up and hold at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != TERM)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register, cleared by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == TERM);

endmodule

// File: rtl/atm_pin_entry.sv
// PIN-entry stage ahead of the ATM transaction FSM. Collects keypad digits,
// compares them with the card's reference PIN, limits wrong attempts and
// aborts the session after a period of keypad inactivity.
module atm_pin_entry
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS     = 4,
    parameter int MAX_TRIES      = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    card_inserted,
    input  logic [4*PIN_DIGITS-1:0] pin_ref,
    input  logic                    key_valid,
    input  logic [3:0]              key_data,
    output logic                    key_ready,
    output logic                    pin_correct,
    output logic                    pin_fail,
    output logic                    card_retain,
    output logic [2:0]              tries_left
);

    localparam int BW    = buf_width(PIN_DIGITS);
    localparam int CNT_W = $clog2(PIN_DIGITS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(PIN_DIGITS);
    localparam logic [2:0]       TRIES_MAX = 3'(MAX_TRIES);

    state_t           state_q, state_d;
    logic [BW-1:0]    buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       tries_q, tries_d;
    logic             key_ready_q, key_ready_d;
    logic             pin_correct_q, pin_correct_d;
    logic             pin_fail_q, pin_fail_d;
    logic             card_retain_q, card_retain_d;

    logic timer_enable;
    logic timer_restart;
    logic timer_expired;
    logic key_taken;
    logic key_is_digit;
    logic key_is_code;
    logic pin_match;

    assign key_taken    = key_valid && key_ready_q;
    assign key_is_digit = (key_data <= 4'd9);
    assign key_is_code  = (key_data <= KEY_ENTER);
    assign pin_match    = (cnt_q == FULL_CNT) && (buf_q == pin_ref);
    assign timer_enable = (state_q == ST_COLLECT);

    atm_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .enable  (timer_enable),
        .restart (timer_restart),
        .expired (timer_expired)
    );

    // Session control: card removal first, then per-state key handling,
    // verification and timeout; outputs are derived from the next state.
    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        cnt_d         = cnt_q;
        tries_d       = tries_q;
        pin_fail_d    = 1'b0;
        timer_restart = 1'b1;

        if ((state_q != ST_IDLE) && !card_inserted) begin
            state_d = ST_IDLE;
            buf_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (card_inserted) begin
                        state_d = ST_COLLECT;
                        tries_d = TRIES_MAX;
                        buf_d   = '0;
                        cnt_d   = '0;
                    end
                end
                ST_COLLECT: begin
                    timer_restart = 1'b0;
                    if (key_taken && key_is_code) begin
                        timer_restart = 1'b1;
                        if (key_is_digit) begin
                            if (cnt_q != FULL_CNT) begin
                                buf_d = {buf_q[BW-5:0], key_data};
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end else if (key_data == KEY_CLEAR) begin
                            buf_d = '0;
                            cnt_d = '0;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end else if (timer_expired) begin
                        pin_fail_d = 1'b1;
                        state_d    = ST_ABORT;
                    end
                end
                ST_VERIFY: begin
                    if (pin_match) begin
                        state_d = ST_GRANTED;
                    end else if (tries_q > 3'd1) begin
                        tries_d    = tries_q - 3'd1;
                        pin_fail_d = 1'b1;
                        buf_d      = '0;
                        cnt_d      = '0;
                        state_d    = ST_COLLECT;
                    end else begin
                        tries_d    = 3'd0;
                        pin_fail_d = 1'b1;
                        state_d    = ST_LOCKED;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        key_ready_d   = (state_d == ST_COLLECT);
        pin_correct_d = (state_d == ST_GRANTED);
        card_retain_d = (state_d == ST_LOCKED);
    end

    // State, datapath and registered outputs with active-low async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            buf_q         <= '0;
            cnt_q         <= '0;
            tries_q       <= TRIES_MAX;
            key_ready_q   <= 1'b0;
            pin_correct_q <= 1'b0;
            pin_fail_q    <= 1'b0;
            card_retain_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            tries_q       <= tries_d;
            key_ready_q   <= key_ready_d;
            pin_correct_q <= pin_correct_d;
            pin_fail_q    <= pin_fail_d;
            card_retain_q <= card_retain_d;
        end
    end

    assign key_ready   = key_ready_q;
    assign pin_correct = pin_correct_q;
    assign pin_fail    = pin_fail_q;
    assign card_retain = card_retain_q;
    assign tries_left  = tries_q;

endmodule

// File: tb/tb_atm_pin_entry.sv
// Directed testbench for atm_pin_entry with a short inactivity timeout.
module tb_atm_pin_entry;

    logic        clk;
    logic        rst;
    logic        card_inserted;
    logic [15:0] pin_ref;
    logic        key_valid;
    logic [3:0]  key_data;
    logic        key_ready;
    logic        pin_correct;
    logic        pin_fail;
    logic        card_retain;
    logic [2:0]  tries_left;

    int assertCount = 0;
    int failCount   = 0;

    atm_pin_entry #(
        .PIN_DIGITS     (4),
        .MAX_TRIES      (3),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .card_inserted (card_inserted),
        .pin_ref       (pin_ref),
        .key_valid     (key_valid),
        .key_data      (key_data),
        .key_ready     (key_ready),
        .pin_correct   (pin_correct),
        .pin_fail      (pin_fail),
        .card_retain   (card_retain),
        .tries_left    (tries_left)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Present one key for a single cycle; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [3:0] key);
        key_valid = 1'b1;
        key_data  = key;
        @(negedge clk);
        key_valid = 1'b0;
        key_data  = 4'h0;
    endtask

    task automatic insertCard();
        card_inserted = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic removeCard();
        card_inserted = 1'b0;
        @(negedge clk);
    endtask

    task automatic enterPin(input logic [15:0] digits);
        logic [15:0] d;
        d = digits;
        for (int i = 3; i >= 0; i--) applyStimulus(d[4*i +: 4]);
        applyStimulus(4'hB);
    endtask

    // Count cycles from the current negedge until pin_fail appears.
    task automatic measureTimeout(input string tag);
        int cycles;
        cycles = 0;
        while (cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (pin_fail) break;
        end
        checkOutput(tag, cycles, 8);
    endtask

    initial begin
        rst           = 1'b0;
        card_inserted = 1'b0;
        pin_ref       = 16'h1234;
        key_valid     = 1'b0;
        key_data      = 4'h0;

        // Reset values
        #12;
        checkOutput("rst_key_ready", key_ready, 0);
        checkOutput("rst_pin_correct", pin_correct, 0);
        checkOutput("rst_pin_fail", pin_fail, 0);
        checkOutput("rst_card_retain", card_retain, 0);
        checkOutput("rst_tries", tries_left, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1: correct PIN
        insertCard();
        checkOutput("t1_key_ready", key_ready, 1);
        enterPin(16'h1234);
        checkOutput("t1_verify_key_ready", key_ready, 0);
        checkOutput("t1_verify_pin_correct", pin_correct, 0);
        @(negedge clk);
        checkOutput("t1_pin_correct", pin_correct, 1);
        checkOutput("t1_tries", tries_left, 3);
        removeCard();
        checkOutput("t1_removed_pin_correct", pin_correct, 0);

        // 2: one wrong attempt then correct
        insertCard();
        enterPin(16'h1235);
        checkOutput("t2_verify_fail", pin_fail, 0);
        @(negedge clk);
        checkOutput("t2_pin_fail", pin_fail, 1);
        checkOutput("t2_tries", tries_left, 2);
        checkOutput("t2_key_ready", key_ready, 1);
        @(negedge clk);
        checkOutput("t2_pin_fail_pulse", pin_fail, 0);
        enterPin(16'h1234);
        @(negedge clk);
        checkOutput("t2_pin_correct", pin_correct, 1);
        removeCard();

        // 3: lockout after three wrong attempts
        insertCard();
        for (int i = 0; i < 3; i++) begin
            enterPin(16'h9999);
            @(negedge clk);
            checkOutput("t3_pin_fail", pin_fail, 1);
            checkOutput("t3_tries", tries_left, 32'(2 - i));
            checkOutput("t3_card_retain", card_retain, (i == 2) ? 1 : 0);
            checkOutput("t3_key_ready", key_ready, (i == 2) ? 0 : 1);
        end
        applyStimulus(4'h1);
        checkOutput("t3_locked_retain", card_retain, 1);
        checkOutput("t3_locked_tries", tries_left, 0);
        checkOutput("t3_locked_fail", pin_fail, 0);
        removeCard();
        checkOutput("t3_removed_retain", card_retain, 0);

        // 4: clear key, then an ignored fifth digit
        insertCard();
        checkOutput("t4_tries_reload", tries_left, 3);
        applyStimulus(4'h1);
        applyStimulus(4'h2);
        applyStimulus(4'hA);
        enterPin(16'h1234);
        @(negedge clk);
        checkOutput("t4_clear_granted", pin_correct, 1);
        removeCard();
        insertCard();
        for (int k = 1; k <= 5; k++) applyStimulus(4'(k));
        applyStimulus(4'hB);
        @(negedge clk);
        checkOutput("t4_fifth_granted", pin_correct, 1);
        removeCard();

        // 5: inactivity timeout and restart by a key on the terminal cycle
        insertCard();
        applyStimulus(4'h1);
        measureTimeout("t5_timeout_cycles");
        checkOutput("t5_abort_key_ready", key_ready, 0);
        checkOutput("t5_abort_tries", tries_left, 3);
        @(negedge clk);
        checkOutput("t5_fail_pulse", pin_fail, 0);
        removeCard();
        insertCard();
        applyStimulus(4'h1);
        repeat (7) @(negedge clk);
        applyStimulus(4'h2);
        checkOutput("t5_restart_no_fail", pin_fail, 0);
        checkOutput("t5_restart_key_ready", key_ready, 1);
        measureTimeout("t5_restart_cycles");
        removeCard();

        // 6: asynchronous reset mid-session
        insertCard();
        enterPin(16'h9999);
        @(negedge clk);
        checkOutput("t6_tries_before", tries_left, 2);
        #2 rst = 1'b0;
        #1;
        checkOutput("t6_rst_key_ready", key_ready, 0);
        checkOutput("t6_rst_tries", tries_left, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_release_collect", key_ready, 1);
        enterPin(16'h1234);
        @(negedge clk);
        checkOutput("t6_granted", pin_correct, 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("t6_rst_pin_correct", pin_correct, 0);
        checkOutput("t6_rst_card_retain", card_retain, 0);
        checkOutput("t6_rst_fail", pin_fail, 0);
        @(negedge clk);
        rst = 1'b1;
        card_inserted = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
